// File: rtl/vram_write_arbiter.sv
// Round-robin arbiter for the video RAM write port, with coordinate-to-address
// translation and a full-frame clear sequencer.
module vram_write_arbiter #(
  parameter int NUM_REQ                 = 4,
  parameter int BITS_PER_COLOUR_CHANNEL = 1,
  parameter     RESOLUTION              = "320x240",
  localparam bit IS_320 = (RESOLUTION == "320x240"),
  localparam int XW     = IS_320 ? 9 : 8,
  localparam int YW     = IS_320 ? 8 : 7,
  localparam int AW     = IS_320 ? 17 : 15,
  localparam int CW     = 3 * BITS_PER_COLOUR_CHANNEL
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NUM_REQ-1:0]    req_valid,
  input  logic [NUM_REQ*XW-1:0] req_x,
  input  logic [NUM_REQ*YW-1:0] req_y,
  input  logic [NUM_REQ*CW-1:0] req_colour,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic                  clear_start,
  input  logic [CW-1:0]         clear_colour,
  output logic                  clear_busy,
  output logic [AW-1:0]         mem_address,
  output logic [CW-1:0]         mem_data,
  output logic                  mem_wren
);

  localparam int WIDTH  = IS_320 ? 320 : 160;
  localparam int HEIGHT = IS_320 ? 240 : 120;
  localparam int SH_HI  = IS_320 ? 8 : 7;
  localparam int SH_LO  = IS_320 ? 6 : 5;
  localparam int PW     = $clog2(NUM_REQ);

  localparam logic [XW-1:0] WIDTH_X  = XW'(WIDTH);
  localparam logic [YW-1:0] HEIGHT_Y = YW'(HEIGHT);
  localparam logic [AW-1:0] LAST     = AW'(WIDTH * HEIGHT - 1);

  typedef enum logic {ARB, CLEAR} state_t;

  state_t        state;
  logic [PW-1:0] ptr;
  logic [AW-1:0] counter;
  logic [CW-1:0] colour_q;

  logic          found;
  logic [PW-1:0] grant_idx;
  int            cand;
  logic [XW-1:0] x_sel;
  logic [YW-1:0] y_sel;
  logic [CW-1:0] colour_sel;
  logic [AW-1:0] pix_address;
  logic          in_range;

  // Search upward from ptr with wrap; a clear request suppresses any grant.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    cand      = 0;
    if (state == ARB && !clear_start) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        cand = int'(ptr) + k;
        if (cand >= NUM_REQ) cand = cand - NUM_REQ;
        if (!found && req_valid[cand]) begin
          found     = 1'b1;
          grant_idx = PW'(cand);
        end
      end
    end
  end

  assign req_ready = found ? (NUM_REQ'(1) << grant_idx) : '0;

  assign x_sel      = req_x[int'(grant_idx)*XW +: XW];
  assign y_sel      = req_y[int'(grant_idx)*YW +: YW];
  assign colour_sel = req_colour[int'(grant_idx)*CW +: CW];

  // y*WIDTH as two shifts: 320 = 256+64, 160 = 128+32.
  assign pix_address = (AW'(y_sel) << SH_HI) + (AW'(y_sel) << SH_LO) + AW'(x_sel);
  assign in_range    = (x_sel < WIDTH_X) && (y_sel < HEIGHT_Y);

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ARB;
      ptr         <= '0;
      counter     <= '0;
      colour_q    <= '0;
      clear_busy  <= 1'b0;
      mem_address <= '0;
      mem_data    <= '0;
      mem_wren    <= 1'b0;
    end else begin
      case (state)
        ARB: begin
          mem_wren <= 1'b0;
          if (clear_start) begin
            // Address 0 is written straight away, so the counter holds the next address.
            state       <= CLEAR;
            clear_busy  <= 1'b1;
            colour_q    <= clear_colour;
            counter     <= AW'(1);
            mem_address <= '0;
            mem_data    <= clear_colour;
            mem_wren    <= 1'b1;
          end else if (found) begin
            ptr         <= (grant_idx == PW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
            mem_address <= pix_address;
            mem_data    <= colour_sel;
            mem_wren    <= in_range;
          end
        end
        CLEAR: begin
          mem_address <= counter;
          mem_data    <= colour_q;
          mem_wren    <= 1'b1;
          if (counter == LAST) begin
            state      <= ARB;
            clear_busy <= 1'b0;
            counter    <= '0;
          end else begin
            counter <= counter + 1'b1;
          end
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_vram_write_arbiter.sv
// Scoreboard bench for vram_write_arbiter: a per-cycle behavioural model queues
// expected writes, and a monitor pops them whenever the DUT asserts mem_wren.
module tb_vram_write_arbiter;

  localparam int NUM_REQ = 4;
  localparam int XW = 9, YW = 8, AW = 17, CW = 3;
  localparam int WIDTH = 320, HEIGHT = 240, TOTAL = WIDTH * HEIGHT;

  logic                  clock = 1'b0;
  logic                  reset = 1'b1;
  logic [NUM_REQ-1:0]    req_valid = '0;
  logic [NUM_REQ*XW-1:0] req_x = '0;
  logic [NUM_REQ*YW-1:0] req_y = '0;
  logic [NUM_REQ*CW-1:0] req_colour = '0;
  logic [NUM_REQ-1:0]    req_ready;
  logic                  clear_start = 1'b0;
  logic [CW-1:0]         clear_colour = '0;
  logic                  clear_busy;
  logic [AW-1:0]         mem_address;
  logic [CW-1:0]         mem_data;
  logic                  mem_wren;

  always #5 clock = ~clock;

  vram_write_arbiter #(
    .NUM_REQ(NUM_REQ),
    .BITS_PER_COLOUR_CHANNEL(1),
    .RESOLUTION("320x240")
  ) dut (
    .clock(clock),
    .reset(reset),
    .req_valid(req_valid),
    .req_x(req_x),
    .req_y(req_y),
    .req_colour(req_colour),
    .req_ready(req_ready),
    .clear_start(clear_start),
    .clear_colour(clear_colour),
    .clear_busy(clear_busy),
    .mem_address(mem_address),
    .mem_data(mem_data),
    .mem_wren(mem_wren)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [CW-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  // Requester side: each slot holds its pixel until the model says it was granted.
  bit            pend[NUM_REQ];
  logic [XW-1:0] px[NUM_REQ];
  logic [YW-1:0] py[NUM_REQ];
  logic [CW-1:0] pc[NUM_REQ];

  int            m_ptr = 0;
  bit            m_clearing = 1'b0;
  int            m_count = 0;
  logic [CW-1:0] m_colour = '0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic setReq(input int i, input logic [XW-1:0] x, input logic [YW-1:0] y, input logic [CW-1:0] c);
    pend[i] = 1'b1;
    px[i] = x;
    py[i] = y;
    pc[i] = c;
  endtask

  task automatic keepBusy(input logic [NUM_REQ-1:0] mask);
    for (int i = 0; i < NUM_REQ; i++)
      if (mask[i] && !pend[i])
        setReq(i, XW'($urandom_range(0, 339)), YW'($urandom_range(0, 249)), CW'($urandom));
  endtask

  // One clock cycle: drive inputs, compare the combinational outputs against the model,
  // then advance the model and queue whatever write the DUT owes next cycle.
  task automatic applyStimulus(input bit rst, input bit clr, input logic [CW-1:0] clr_col);
    logic [NUM_REQ-1:0] exp_ready;
    int                 idx;
    wr_t                w;
    @(negedge clock);
    reset        = rst;
    clear_start  = clr;
    clear_colour = clr_col;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_valid[i]               = pend[i];
      req_x[i*XW +: XW]          = px[i];
      req_y[i*YW +: YW]          = py[i];
      req_colour[i*CW +: CW]     = pc[i];
    end
    #1;
    checkOutput("write_latency", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
    if (rst) begin
      m_ptr = 0;
      m_clearing = 1'b0;
      m_count = 0;
      return;
    end
    checkOutput("clear_busy", 64'(clear_busy), 64'(m_clearing));
    exp_ready = '0;
    if (m_clearing) begin
      w.addr = AW'(m_count);
      w.data = m_colour;
      exp_q.push_back(w);
      m_count++;
      if (m_count == TOTAL) m_clearing = 1'b0;
    end else if (clr) begin
      w.addr = '0;
      w.data = clr_col;
      exp_q.push_back(w);
      m_colour = clr_col;
      m_count = 1;
      m_clearing = 1'b1;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = (m_ptr + k) % NUM_REQ;
        if (pend[idx]) begin
          exp_ready[idx] = 1'b1;
          m_ptr = (idx + 1) % NUM_REQ;
          break;
        end
      end
    end
    checkOutput("req_ready", 64'(req_ready), 64'(exp_ready));
    for (int i = 0; i < NUM_REQ; i++) begin
      if (exp_ready[i]) begin
        if (int'(px[i]) < WIDTH && int'(py[i]) < HEIGHT) begin
          w.addr = AW'(int'(py[i]) * WIDTH + int'(px[i]));
          w.data = pc[i];
          exp_q.push_back(w);
        end
        pend[i] = 1'b0;
      end
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 16; n++) begin
      if (!(pend[0] || pend[1] || pend[2] || pend[3])) break;
      applyStimulus(1'b0, 1'b0, '0);
    end
    applyStimulus(1'b0, 1'b0, '0);
  endtask

  // Monitor: every DUT write must match the oldest outstanding expectation.
  initial begin
    wr_t e;
    forever begin
      @(negedge clock);
      if (mem_wren !== 1'b0) begin
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_write", 64'(mem_address), 64'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          checkOutput("write_addr", 64'(mem_address), 64'(e.addr));
          checkOutput("write_data", 64'(mem_data), 64'(e.data));
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < NUM_REQ; i++) begin
      pend[i] = 1'b0; px[i] = '0; py[i] = '0; pc[i] = '0;
    end
    applyStimulus(1'b1, 1'b0, '0);
    applyStimulus(1'b1, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("reset_wren", 64'(mem_wren), 64'd0);
    checkOutput("reset_address", 64'(mem_address), 64'd0);
    checkOutput("reset_data", 64'(mem_data), 64'd0);

    setReq(0, 9'd5, 8'd3, 3'b101);
    applyStimulus(1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("single_address", 64'(mem_address), 64'd965);
    checkOutput("single_wren", 64'(mem_wren), 64'd1);

    for (int n = 0; n < 8; n++) begin
      keepBusy(4'b1111);
      applyStimulus(1'b0, 1'b0, '0);
    end
    drain();

    // Grant requester 2 alone so the pointer lands on 3, then contend with 0 and 2.
    setReq(2, 9'd100, 8'd50, 3'b011);
    applyStimulus(1'b0, 1'b0, '0);
    for (int n = 0; n < 6; n++) begin
      keepBusy(4'b0101);
      applyStimulus(1'b0, 1'b0, '0);
    end
    drain();

    setReq(1, 9'd320, 8'd10, 3'b111);
    applyStimulus(1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("oor_x_wren", 64'(mem_wren), 64'd0);
    setReq(3, 9'd10, 8'd240, 3'b110);
    applyStimulus(1'b0, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("oor_y_wren", 64'(mem_wren), 64'd0);

    applyStimulus(1'b0, 1'b1, 3'b100);
    for (int n = 1; n < 1000; n++)
      applyStimulus(1'b0, (n == 20), 3'b001);
    applyStimulus(1'b1, 1'b0, '0);
    applyStimulus(1'b0, 1'b0, '0);
    checkOutput("midclear_reset_wren", 64'(mem_wren), 64'd0);
    checkOutput("midclear_reset_busy", 64'(clear_busy), 64'd0);
    for (int n = 0; n < 6; n++) begin
      keepBusy(4'b1111);
      applyStimulus(1'b0, 1'b0, '0);
    end
    drain();

    setReq(1, 9'd7, 8'd7, 3'b101);
    applyStimulus(1'b0, 1'b1, 3'b010);
    for (int n = 1; n < TOTAL + 2; n++)
      applyStimulus(1'b0, (n == 500), 3'b111);
    drain();

    for (int n = 0; n < 1500; n++) begin
      keepBusy(NUM_REQ'($urandom));
      applyStimulus(1'b0, 1'b0, '0);
    end
    drain();
    applyStimulus(1'b0, 1'b0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vram_write_arbiter.md
# vram_write_arbiter

Sequences all writes into the video memory behind the VGA controller. It shares the single video-memory write port between NUM_REQ Mandelbrot pixel engines using round-robin arbitration. It translates each granted (x,y) dot coordinate into a linear memory address, and runs a full-frame clear sequence on command. It sits between the compute cores and the write port of the dual-port video RAM; the VGA controller owns the read port.

## Interface
- NUM_REQ, 4 — number of requesting pixel engines (2..8).
- BITS_PER_COLOUR_CHANNEL, 1 — colour word is 3*BITS_PER_COLOUR_CHANNEL bits (CW).
- RESOLUTION, "320x240" — "320x240" or "160x120"; sets XW/YW/AW to 9/8/17 or 8/7/15, and WIDTH/HEIGHT to 320/240 or 160/120.

Ports:
- clock  in  1  — system clock; sole clock domain.
- reset  in  1  — synchronous, active-high reset.
- req_valid  in  NUM_REQ  — requester i has a pixel pending.
- req_x  in  NUM_REQ*XW  — packed x coordinates; requester i occupies slice i.
- req_y  in  NUM_REQ*YW  — packed y coordinates.
- req_colour  in  NUM_REQ*CW  — packed pixel colours.
- req_ready  out  NUM_REQ  — one-hot grant; transfer occurs when req_valid[i] and req_ready[i] are both high on a rising edge.
- clear_start  in  1  — single-cycle pulse that starts a frame clear.
- clear_colour  in  CW  — fill colour, sampled on the accepted clear_start.
- clear_busy  out  1  — high while a clear is in progress.
- mem_address  out  AW  — video RAM write address.
- mem_data  out  CW  — video RAM write data.
- mem_wren  out  1  — video RAM write enable, registered.

## Operation
- State machine has two states, ARB and CLEAR. Reset enters ARB.
- ARB:
  - req_ready is combinational. Among asserted req_valid bits, grant the first index at or after priority pointer ptr, searching upward with wrap from NUM_REQ-1 to 0.
  - On grant to i, ptr becomes (i+1) mod NUM_REQ. With no valid requests, ptr holds and req_ready=0.
- Accepted pixel:
  - Address = y*WIDTH + x, computed as (y<<8)+(y<<6)+x for 320x240 or (y<<7)+(y<<5)+x for 160x120, at full AW width with no truncation.
  - Registered to mem_address/mem_data, with mem_wren=1 on the next cycle.
  - Coordinates with x>=WIDTH or y>=HEIGHT are still acknowledged (req_ready=1) but produce mem_wren=0: silently dropped.
- clear_start in ARB:
  - Takes priority over any pending request that cycle; no grant is issued that cycle (req_ready=0).
  - Latches clear_colour, zeroes the address counter, enters CLEAR, and asserts clear_busy from the next cycle.
- CLEAR:
  - req_ready=0. Each cycle emits one write of the latched colour at counter, then increments the counter.
  - After writing address WIDTH*HEIGHT-1 (76799 or 19199), returns to ARB; clear_busy falls the cycle after the last write is issued.
- clear_start during CLEAR is ignored: no restart, no colour change.
- Pending requests are never lost; requesters hold req_valid and data stable until granted.

## Timing
- Reset values: req_ready=0, clear_busy=0, mem_wren=0, mem_address=0, mem_data=0, ptr=0, counter=0, state=ARB.
- Grant-to-write latency is 1 cycle: grant in cycle N, mem_wren=1 in cycle N+1.
- Peak throughput is 1 write per cycle. Back-to-back grants to different requesters are allowed.
- Fairness: with all requesters continuously valid, each receives exactly one grant per NUM_REQ cycles.
- Clear duration: first clear write is in cycle N+1 after the clear_start edge in cycle N. Exactly WIDTH*HEIGHT consecutive cycles have mem_wren=1. Addresses run strictly ascending 0..max with no gaps.
- Request grants resume in the first cycle that state=ARB.
- Reset asserted mid-clear or mid-write: on the next edge all outputs take their reset values and any in-flight write is abandoned (mem_wren=0).
- A grant issued in the last ARB cycle before clear_start still completes its write one cycle later, before the first clear write.

## Test plan
- Reset, then single request: req_valid=0001, x=5, y=3, colour=3'b101 → req_ready=0001 for one cycle; next cycle mem_address=965, mem_data=101, mem_wren=1.
- Fairness: req_valid=1111 held for 8 cycles → grants 0,1,2,3,0,1,2,3; mem_wren=1 on 8 consecutive cycles.
- Sparse wrap: ptr=3, req_valid=0101 → grant 0, then 2, then 0; requester 1 never granted.
- Out of range: x=320, y=10 → req_ready pulses; mem_wren stays 0.
- Clear: clear_start with colour=3'b010 while req_valid=0010 → no grant that cycle. 76800 writes of 010 at addresses 0..76799, req_ready=0 throughout, clear_busy low afterward, then requester 1 granted. A second clear_start mid-clear is ignored.
- Reset at clear address 1000 → next cycle mem_wren=0, clear_busy=0, state ARB, ptr=0.
